// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register with stall/flush and per-slot valid.
// Optional BubbleCnt/StallCnt counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_stage_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
`ifdef ID_EX_PERF_CNT_EN
   ,
   parameter int unsigned CNT_W  = 32
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              StallE,
   input  logic              FlushE,
   input  logic              ValidD,
   input  logic              MemtoRegD,
   input  logic              MemWriteD,
   input  logic              BranchD,
   input  logic              ALUSrcD,
   input  logic              RegDstD,
   input  logic              RegWriteD,
   input  logic              ZeroOrSignD,
   input  logic [3:0]        ALUControlD,
   input  logic [DATA_W-1:0] RD1D,
   input  logic [DATA_W-1:0] RD2D,
   input  logic [REG_AW-1:0] RsD,
   input  logic [REG_AW-1:0] RtD,
   input  logic [REG_AW-1:0] RdD,
   input  logic [DATA_W-1:0] SignImmD,
   input  logic [DATA_W-1:0] PCPlus4D,
   output logic              ValidE,
   output logic              MemtoRegE,
   output logic              MemWriteE,
   output logic              BranchE,
   output logic              ALUSrcE,
   output logic              RegDstE,
   output logic              RegWriteE,
   output logic              ZeroOrSignE,
   output logic [3:0]        ALUControlE,
   output logic [DATA_W-1:0] RD1E,
   output logic [DATA_W-1:0] RD2E,
   output logic [REG_AW-1:0] RsE,
   output logic [REG_AW-1:0] RtE,
   output logic [REG_AW-1:0] RdE,
   output logic [DATA_W-1:0] SignImmE,
   output logic [DATA_W-1:0] PCPlus4E
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  BubbleCnt,
   output logic [CNT_W-1:0]  StallCnt
`endif
);

   typedef struct packed {
      logic              valid;
      logic              memtoreg;
      logic              memwrite;
      logic              branch;
      logic              alusrc;
      logic              regdst;
      logic              regwrite;
      logic              zeroorsign;
      logic [3:0]        aluctl;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] signimm;
      logic [DATA_W-1:0] pcplus4;
   } slot_t;

   slot_t slot_d, slot_q;

   always_comb begin
      slot_d = slot_q;
      if (FlushE) begin
         slot_d = '0;
      end else if (!StallE) begin
         slot_d.valid      = ValidD;
         slot_d.memtoreg   = MemtoRegD;
         slot_d.alusrc     = ALUSrcD;
         slot_d.regdst     = RegDstD;
         slot_d.zeroorsign = ZeroOrSignD;
         slot_d.aluctl     = ALUControlD;
         slot_d.rd1        = RD1D;
         slot_d.rd2        = RD2D;
         slot_d.rs         = RsD;
         slot_d.rt         = RtD;
         slot_d.rd         = RdD;
         slot_d.signimm    = SignImmD;
         slot_d.pcplus4    = PCPlus4D;
         // A non-valid slot must never commit architectural state.
         slot_d.memwrite   = MemWriteD & ValidD;
         slot_d.branch     = BranchD   & ValidD;
         slot_d.regwrite   = RegWriteD & ValidD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign ValidE      = slot_q.valid;
   assign MemtoRegE   = slot_q.memtoreg;
   assign MemWriteE   = slot_q.memwrite;
   assign BranchE     = slot_q.branch;
   assign ALUSrcE     = slot_q.alusrc;
   assign RegDstE     = slot_q.regdst;
   assign RegWriteE   = slot_q.regwrite;
   assign ZeroOrSignE = slot_q.zeroorsign;
   assign ALUControlE = slot_q.aluctl;
   assign RD1E        = slot_q.rd1;
   assign RD2E        = slot_q.rd2;
   assign RsE         = slot_q.rs;
   assign RtE         = slot_q.rt;
   assign RdE         = slot_q.rd;
   assign SignImmE    = slot_q.signimm;
   assign PCPlus4E    = slot_q.pcplus4;

`ifdef ID_EX_PERF_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      if (FlushE) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end else if (StallE) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign BubbleCnt = bubble_cnt_q;
   assign StallCnt  = stall_cnt_q;
`endif

endmodule
